// File: rtl/mux_2x1_reg_pkg.sv
// Shared definitions for the 2:1 operand selector: default width, word type and select encodings.
package mux_2x1_reg_pkg;

  localparam int DEFAULT_DATA_WIDTH = 11;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_word_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage : mux_2x1_reg_pkg

// File: rtl/mux_2x1_comb.sv
// Purely combinational 2:1 word selector; no width change, no sign handling.
import mux_2x1_reg_pkg::*;

module mux_2x1_comb #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_0,
  input  logic                  select_2x1,
  output logic [DATA_WIDTH-1:0] sel_data
);

  assign sel_data = (select_2x1 == SEL_IN1) ? in_1 : in_0;

endmodule : mux_2x1_comb

// File: rtl/mux_2x1_reg.sv
// 2:1 data selector with an optional enable-gated output register (1-cycle latency)
// or a zero-latency combinational path, chosen at build time by REGISTERED.
import mux_2x1_reg_pkg::*;

module mux_2x1_reg #(
  parameter int                   DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter bit                   REGISTERED  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_0,
  input  logic                  select_2x1,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] mux_out
);

  logic [DATA_WIDTH-1:0] sel_data;

  mux_2x1_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux_2x1_comb (
    .in_1       (in_1),
    .in_0       (in_0),
    .select_2x1 (select_2x1),
    .sel_data   (sel_data)
  );

  generate
    if (REGISTERED) begin : g_reg
      logic [DATA_WIDTH-1:0] mux_out_reg;

      // reset wins over enable; with enable low the word is held
      always_ff @(posedge clk) begin
        if (reset) begin
          mux_out_reg <= RESET_VALUE;
        end else if (enable) begin
          mux_out_reg <= sel_data;
        end
      end

      assign mux_out = mux_out_reg;
    end else begin : g_comb
      // clock, reset and enable deliberately play no part in this build
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, enable};
      assign mux_out     = sel_data;
    end
  endgenerate

endmodule : mux_2x1_reg

// File: tb/tb_mux_2x1_reg.sv
// Self-checking bench: registered build via an expected-value queue, combinational build checked in the same timestep.
module tb_mux_2x1_reg;

  localparam int W = 11;
  localparam logic [W-1:0] RV = '0;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_1;
  logic [W-1:0] in_0;
  logic         select_2x1;
  logic         enable;
  logic [W-1:0] reg_out;
  logic [W-1:0] comb_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_reg;

  mux_2x1_reg #(
    .DATA_WIDTH  (W),
    .REGISTERED  (1'b1),
    .RESET_VALUE (RV)
  ) u_dut_reg (
    .clk        (clk),
    .reset      (reset),
    .in_1       (in_1),
    .in_0       (in_0),
    .select_2x1 (select_2x1),
    .enable     (enable),
    .mux_out    (reg_out)
  );

  mux_2x1_reg #(
    .DATA_WIDTH  (W),
    .REGISTERED  (1'b0),
    .RESET_VALUE (RV)
  ) u_dut_comb (
    .clk        (clk),
    .reset      (reset),
    .in_1       (in_1),
    .in_0       (in_0),
    .select_2x1 (select_2x1),
    .enable     (enable),
    .mux_out    (comb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%03h", tag, obs);
    end
  endtask

  // One transaction: drive on the falling edge, check the combinational build
  // immediately, queue the registered expectation, compare after the rising edge.
  task automatic drive(input string tag, input logic rst, input logic en, input logic sel,
                       input logic [W-1:0] d1, input logic [W-1:0] d0);
    logic [W-1:0] sel_exp;
    logic [W-1:0] popped;
    @(negedge clk);
    reset      = rst;
    enable     = en;
    select_2x1 = sel;
    in_1       = d1;
    in_0       = d0;
    sel_exp    = sel ? d1 : d0;
    #1;
    check({tag, "/comb"}, comb_out, sel_exp);
    if (rst)     model_reg = RV;
    else if (en) model_reg = sel_exp;
    exp_q.push_back(model_reg);
    @(posedge clk);
    #1;
    check({tag, "/comb_edge"}, comb_out, sel_exp);
    if (exp_q.size() == 0) begin
      checks_cnt++;
      errors_cnt++;
      $display("FAIL %s/queue: got empty expected entry", tag);
    end else begin
      popped = exp_q.pop_front();
      check({tag, "/reg"}, reg_out, popped);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; select_2x1 = 1'b0; in_1 = '0; in_0 = '0;
    model_reg = 'x;

    // reset with enable high: reset has priority
    drive("reset",        1, 1, 1, 11'h064, 11'h749);
    drive("after_reset",  0, 1, 1, 11'h064, 11'h749);
    // select in_1, then change the unselected input
    drive("sel1",         0, 1, 1, 11'h000, 11'h049);
    drive("sel1_in0_chg", 0, 1, 1, 11'h000, 11'h749);
    // toggle select
    drive("tog0",         0, 1, 0, 11'h000, 11'h749);
    drive("tog1",         0, 1, 1, 11'h000, 11'h749);
    drive("tog0b",        0, 1, 0, 11'h000, 11'h749);
    // unselected input change, then select it
    drive("in1_chg",      0, 1, 0, 11'h064, 11'h749);
    drive("sel_in1",      0, 1, 1, 11'h064, 11'h749);
    drive("in1_zero",     0, 1, 1, 11'h000, 11'h749);
    // simultaneous select and data change
    drive("both_chg",     0, 1, 0, 11'h111, 11'h2AA);
    // hold with enable low, then reset with enable low
    drive("load",         0, 1, 1, 11'h555, 11'h2AA);
    drive("hold0",        0, 0, 0, 11'h3FF, 11'h123);
    drive("hold1",        0, 0, 1, 11'h0F0, 11'h70F);
    drive("rst_en0",      1, 0, 1, 11'h0F0, 11'h70F);
    // mid-stream reset and resume
    drive("pre_rst",      0, 1, 1, 11'h7FF, 11'h000);
    drive("mid_rst",      1, 1, 0, 11'h7FF, 11'h456);
    drive("resume",       0, 1, 0, 11'h7FF, 11'h123);

    for (int i = 0; i < 40; i++) begin
      drive($sformatf("rnd%0d", i),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_2x1_reg

// File: doc/mux_2x1_reg.md
Name: mux_2x1_reg

Overview:
Parameterised 2:1 data selector with an optional output register, used to pick an operand source, e.g. external input vs. data-memory read data feeding operand B.
- select_2x1=1 routes in_1; select_2x1=0 routes in_0.
- Default build registers the selected word on the clock edge. A combinational build option is kept for paths where zero latency is required.

Parameters:
- DATA_WIDTH, 11, width of both data inputs and the output.
- REGISTERED, 1, 1 = output registered (1-cycle latency); 0 = purely combinational output.
- RESET_VALUE, '0, value loaded into the output register on reset; DATA_WIDTH bits.

Ports:
- clk  input  1  single system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- in_1  input  DATA_WIDTH  data selected when select_2x1=1.
- in_0  input  DATA_WIDTH  data selected when select_2x1=0.
- select_2x1  input  1  selection control.
- enable  input  1  output-register load enable; ignored when REGISTERED=0.
- mux_out  output  DATA_WIDTH  selected data.

Behaviour:
- Selection function: sel_data = select_2x1 ? in_1 : in_0, bit-for-bit, no width change, no sign handling.
- REGISTERED=1, at each rising clk edge:
  - reset=1 → mux_out <= RESET_VALUE.
  - else if enable=1 → mux_out <= sel_data.
  - else → mux_out holds its previous value.
- REGISTERED=1 timing:
  - Latency is exactly 1 cycle from the input/select change to mux_out.
  - reset has priority over enable.
  - reset asserted mid-stream clears the output on the next edge; loading resumes on the first edge after reset deasserts with enable=1.
  - Simultaneous change of select and data in one cycle: the output after the edge reflects the new select applied to the new data.
- REGISTERED=0:
  - mux_out = sel_data continuously, zero latency.
  - clk, reset and enable have no effect on mux_out.
- Power-up before the first reset: mux_out is undefined for REGISTERED=1. The system must issue reset before use.
- Unchanged select with a changing non-selected input: mux_out must not change.
- All widths ≥ 1 are legal; DATA_WIDTH=1 degenerates to a single-bit mux.

Decomposition:
- Shared package holds:
  - the DATA_WIDTH default constant (11);
  - typedef data_word_t = logic [DATA_WIDTH-1:0];
  - SEL_IN0=1'b0 and SEL_IN1=1'b1 constants.
- Natural sub-module: mux_2x1_comb, a purely combinational selector. The top instantiates it and wraps the optional register with a generate block on REGISTERED.

Test Plan:
- Reset: reset=1 for 1 cycle with in_1=0x064, in_0=0x749 → mux_out=RESET_VALUE (0x000) after the edge. enable=1, select=1 next cycle → 0x064.
- Select in_1: in_1=0x000, in_0=0x049, sel=1 → mux_out=0x000 one cycle later. Then in_0=0x749 with sel=1 held → mux_out stays 0x000.
- Toggle select: in_1=0x000, in_0=0x749; sel 1→0→1→0 on successive cycles → mux_out 0x749, 0x000, 0x749, each lagging its select by 1 cycle.
- Non-selected change then select: sel=0, in_1 changes 0x000→0x064 → mux_out stays 0x749. Then sel=1 → 0x064. Then in_1=0x000 → 0x000.
- Hold: enable=0 while select/data toggle → mux_out frozen. Reset asserted with enable=0 → still clears to RESET_VALUE.
- REGISTERED=0 build: same stimulus → mux_out follows sel_data in the same timestep; reset and enable have no effect.
